// File: rtl/frame_window_sequencer_pkg.sv
// Shared definitions for the frame window sequencer and the line buffers it drives.
package frame_window_sequencer_pkg;

  localparam int IMG_WIDTH = 640;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FILL   = 3'd2,
    ST_PRIME  = 3'd3,
    ST_STREAM = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/frame_position_counter.sv
// Column/row position counter: column wraps at WIDTH-1 and carries into the row.
module frame_position_counter
  import frame_window_sequencer_pkg::*;
#(
  parameter int WIDTH    = IMG_WIDTH,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 11,
  parameter int ROW_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // position register with clear-to-origin and end-of-line wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= ROW_W'(ROW_INIT);
    end else if (i_en) begin
      if (r_col == COL_W'(WIDTH - 1)) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/frame_window_sequencer.sv
// Frame controller for the 3-line-buffer 3x3 window generator: clears, primes,
// streams and drains the buffers, and tags each emitted window with its position.
module frame_window_sequencer
  import frame_window_sequencer_pkg::*;
#(
  parameter int MAX_HEIGHT = 2047,
  parameter int PIX_W      = 8,
  parameter int ROW_W      = 11,
  parameter int COL_W      = 10,
  parameter int CNT_W      = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [ROW_W-1:0] i_frame_height,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_underrun,
  input  logic             i_s_valid,
  input  logic [PIX_W-1:0] i_s_data,
  output logic             o_s_ready,
  output logic             o_lb_rst,
  output logic             o_lb_valid,
  output logic [PIX_W-1:0] o_lb_data,
  input  logic             i_lb_out_valid,
  output logic             o_win_valid,
  output logic [ROW_W-1:0] o_win_row,
  output logic [COL_W-1:0] o_win_col,
  output logic             o_win_first_row,
  output logic             o_win_last_row,
  output logic             o_win_first_col,
  output logic             o_win_last_col
);

  state_t           r_state;
  state_t           w_next;
  logic [ROW_W-1:0] r_height;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_in_cnt;
  logic             r_underrun;

  logic             w_start_ok;
  logic             w_in_en;
  logic             w_fill_done;
  logic             w_stream_end;
  logic             w_win_live;
  logic             w_win_valid;
  logic             w_win_last_col;
  logic             w_win_last;
  logic [COL_W-1:0] w_in_col;
  logic [ROW_W-1:0] w_in_row;
  logic [COL_W-1:0] w_win_col;
  logic [ROW_W-1:0] w_win_row;

  // compared one bit wider so the range check stays meaningful at MAX_HEIGHT = 2^ROW_W-1
  assign w_start_ok = (r_state == ST_IDLE) && i_start &&
                      (i_frame_height >= ROW_W'(3)) &&
                      ({1'b0, i_frame_height} <= (ROW_W + 1)'(MAX_HEIGHT));

  assign w_in_en = ((r_state == ST_FILL) && i_s_valid) || (r_state == ST_STREAM);

  // input position (3, 0) is the 3*IMG_WIDTH+1-th accepted pixel
  assign w_fill_done  = (w_in_row == ROW_W'(3)) && (w_in_col == COL_W'(0));
  assign w_stream_end = (r_in_cnt + CNT_W'(1)) >= r_total;

  assign w_win_live     = ((r_state == ST_STREAM) || (r_state == ST_FLUSH)) &&
                          (w_win_row <= (r_height - ROW_W'(2)));
  assign w_win_valid    = i_lb_out_valid && w_win_live;
  assign w_win_last_col = (w_win_col == COL_W'(IMG_WIDTH - 1));
  assign w_win_last     = w_win_valid && w_win_last_col && (w_win_row == (r_height - ROW_W'(2)));

  frame_position_counter #(
    .WIDTH(IMG_WIDTH), .COL_W(COL_W), .ROW_W(ROW_W), .ROW_INIT(0)
  ) u_in_pos (
    .clk(clk), .rst(rst), .i_clr(w_start_ok), .i_en(w_in_en),
    .o_col(w_in_col), .o_row(w_in_row)
  );

  frame_position_counter #(
    .WIDTH(IMG_WIDTH), .COL_W(COL_W), .ROW_W(ROW_W), .ROW_INIT(1)
  ) u_win_pos (
    .clk(clk), .rst(rst), .i_clr(w_start_ok), .i_en(w_win_valid),
    .o_col(w_win_col), .o_row(w_win_row)
  );

  // state, frame geometry, pixel count and sticky underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_height   <= '0;
      r_total    <= '0;
      r_in_cnt   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_height   <= i_frame_height;
        r_total    <= CNT_W'(IMG_WIDTH) * CNT_W'(i_frame_height);
        r_in_cnt   <= '0;
        r_underrun <= 1'b0;
      end else if (w_in_en) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
        if ((r_state == ST_STREAM) && !i_s_valid) begin
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // next state and pixel-path outputs
  always_comb begin
    w_next     = r_state;
    o_s_ready  = 1'b0;
    o_lb_valid = 1'b0;
    o_lb_data  = '0;
    case (r_state)
      ST_IDLE:  w_next = w_start_ok ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: w_next = ST_FILL;
      ST_FILL: begin
        o_s_ready  = 1'b1;
        o_lb_valid = i_s_valid;
        o_lb_data  = i_s_data;
        w_next     = (i_s_valid && w_fill_done) ? ST_PRIME : ST_FILL;
      end
      ST_PRIME: w_next = i_lb_out_valid ? ST_STREAM : ST_PRIME;
      ST_STREAM: begin
        o_s_ready  = 1'b1;
        o_lb_valid = 1'b1;
        o_lb_data  = i_s_valid ? i_s_data : '0;
        if (w_win_last) begin
          w_next = ST_DONE;
        end else if (w_stream_end) begin
          w_next = ST_FLUSH;
        end else begin
          w_next = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        o_lb_valid = 1'b1;
        w_next     = w_win_last ? ST_DONE : ST_FLUSH;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign o_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done     = (r_state == ST_DONE);
  assign o_lb_rst   = rst || (r_state == ST_CLEAR) || (r_state == ST_DONE);
  assign o_underrun = r_underrun;

  assign o_win_valid     = w_win_valid;
  assign o_win_row       = w_win_row;
  assign o_win_col       = w_win_col;
  assign o_win_first_row = w_win_valid && (w_win_row == ROW_W'(1));
  assign o_win_last_row  = w_win_valid && (w_win_row == (r_height - ROW_W'(2)));
  assign o_win_first_col = w_win_valid && (w_win_col == COL_W'(0));
  assign o_win_last_col  = w_win_valid && w_win_last_col;

endmodule

// File: tb/tb_frame_window_sequencer.sv
// Self-checking bench: randomized source/line-buffer handshakes against a frame-level model.
module tb_frame_window_sequencer;

  localparam int W = 640;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [10:0] i_frame_height;
  logic        o_busy, o_done, o_underrun;
  logic        i_s_valid;
  logic [7:0]  i_s_data;
  logic        o_s_ready, o_lb_rst, o_lb_valid;
  logic [7:0]  o_lb_data;
  logic        i_lb_out_valid;
  logic        o_win_valid;
  logic [10:0] o_win_row;
  logic [9:0]  o_win_col;
  logic        o_win_first_row, o_win_last_row, o_win_first_col, o_win_last_col;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_window_sequencer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_frame_height(i_frame_height),
    .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun),
    .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
    .o_lb_rst(o_lb_rst), .o_lb_valid(o_lb_valid), .o_lb_data(o_lb_data),
    .i_lb_out_valid(i_lb_out_valid), .o_win_valid(o_win_valid),
    .o_win_row(o_win_row), .o_win_col(o_win_col),
    .o_win_first_row(o_win_first_row), .o_win_last_row(o_win_last_row),
    .o_win_first_col(o_win_first_col), .o_win_last_col(o_win_last_col)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame of height h. gap_at >= 0 starves the source for 5 cycles from that
  // STREAM cycle; abort_at >= 0 applies rst at that STREAM cycle. Entered and left
  // 1 time unit after a rising edge.
  task automatic run_frame(input int h, input int gap_at, input int abort_at);
    int phase, nxt, acc, zeros, wins, wr, scyc, nwin, nz, exp_acc, r, c;
    int obs_acc, obs_zero, obs_win, obs_done, c_first, c_last;
    bit fin, exp_ur, sv, ov, exp_wv, exp_lbv;
    logic [7:0] sd;
    nwin = W * (h - 2);
    nz = (gap_at >= 0) ? 5 : 0;
    phase = 0; acc = 0; zeros = 0; wins = 0; wr = 0; scyc = 0;
    obs_acc = 0; obs_zero = 0; obs_win = 0; obs_done = 0; c_first = 0; c_last = 0;
    fin = 1'b0; exp_ur = 1'b0;
    i_start = 1'b1; i_frame_height = 11'(h); i_s_valid = 1'b0; i_lb_out_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_s_ready", 32'(o_s_ready), 32'd0);
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (phase == 1) sv = ($urandom_range(3) != 0);
      else if (phase == 3) sv = !(gap_at >= 0 && scyc >= gap_at && scyc < gap_at + 5);
      else sv = ($urandom_range(1) == 1);
      sd = 8'($urandom);
      ov = (wr >= 3 * W + 1) && ($urandom_range(7) != 0);
      i_s_valid = sv; i_s_data = sd; i_lb_out_valid = ov;
      i_start = (phase == 1 && acc == 10);
      i_frame_height = i_start ? 11'd5 : 11'(h);
      @(negedge clk);
      exp_wv  = ov && (phase == 3 || phase == 4) && (wins < nwin);
      exp_lbv = (phase == 1) ? sv : (phase == 3 || phase == 4);
      check("busy", 32'(o_busy), 32'(phase != 5));
      check("s_ready", 32'(o_s_ready), 32'(phase == 1 || phase == 3));
      check("lb_valid", 32'(o_lb_valid), 32'(exp_lbv));
      if (exp_lbv)
        check("lb_data", 32'(o_lb_data), 32'((phase == 1 || (phase == 3 && sv)) ? sd : 8'd0));
      check("lb_rst", 32'(o_lb_rst), 32'(phase == 0 || phase == 5));
      check("done", 32'(o_done), 32'(phase == 5));
      check("underrun", 32'(o_underrun), 32'(exp_ur));
      check("win_valid", 32'(o_win_valid), 32'(exp_wv));
      r = 1 + wins / W;
      c = wins % W;
      if (exp_wv) begin
        check("win_row", 32'(o_win_row), 32'(r));
        check("win_col", 32'(o_win_col), 32'(c));
      end
      check("win_flags", 32'({o_win_first_row, o_win_last_row, o_win_first_col, o_win_last_col}),
            exp_wv ? 32'({r == 1, r == h - 2, c == 0, c == W - 1}) : 32'd0);
      if (o_s_ready && sv) obs_acc++;
      if (o_lb_valid && o_s_ready && !sv) obs_zero++;
      if (o_win_valid) obs_win++;
      if (o_done) obs_done++;
      if (o_win_first_row && o_win_first_col) c_first++;
      if (o_win_last_row && o_win_last_col) c_last++;
      if (exp_lbv) wr++;
      nxt = phase;
      case (phase)
        0: nxt = 1;
        1: if (sv) begin
             acc++;
             if (acc == 3 * W + 1) nxt = 2;
           end
        2: if (ov) nxt = 3;
        3: begin
             if (sv) acc++;
             else begin zeros++; exp_ur = 1'b1; end
             scyc++;
             if (acc + zeros >= W * h) nxt = 4;
           end
        5: fin = 1'b1;
        default: ;
      endcase
      if (exp_wv) begin
        wins++;
        if (wins == nwin) nxt = 5;
      end
      phase = nxt;
      if (abort_at >= 0 && phase == 3 && scyc == abort_at) begin
        @(posedge clk); #1;
        rst = 1'b1; i_s_valid = 1'b0; i_lb_out_valid = 1'b0; i_start = 1'b0;
        @(negedge clk);
        check("abort_lb_rst_comb", 32'(o_lb_rst), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_lb_rst", 32'(o_lb_rst), 32'd1);
        check("abort_underrun", 32'(o_underrun), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_s_ready", 32'(o_s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_busy", 32'(o_busy), 32'd0);
        check("post_abort_lb_rst", 32'(o_lb_rst), 32'd0);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    check("frame_finished", 32'(fin), 32'd1);
    exp_acc = ((W * h > 3 * W + 1) ? W * h : 3 * W + 2) - nz;
    check("total_accepts", 32'(obs_acc), 32'(exp_acc));
    check("zero_inserts", 32'(obs_zero), 32'(nz));
    check("window_count", 32'(obs_win), 32'(nwin));
    check("done_pulses", 32'(obs_done), 32'd1);
    check("corner_first", 32'(c_first), 32'd1);
    check("corner_last", 32'(c_last), 32'd1);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_frame_height = 11'd0;
    i_s_valid = 1'b0; i_s_data = 8'd0; i_lb_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_s_ready", 32'(o_s_ready), 32'd0);
    check("rst_lb_valid", 32'(o_lb_valid), 32'd0);
    check("rst_lb_rst", 32'(o_lb_rst), 32'd1);
    check("rst_win_valid", 32'(o_win_valid), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(4, -1, -1);

    for (int hb = 0; hb < 3; hb++) begin
      i_start = 1'b1; i_frame_height = 11'(hb);
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("bad_h_busy", 32'(o_busy), 32'd0);
        check("bad_h_s_ready", 32'(o_s_ready), 32'd0);
        check("bad_h_lb_rst", 32'(o_lb_rst), 32'd0);
        @(posedge clk); #1;
      end
    end

    run_frame(4, 50, -1);
    run_frame(5, -1, -1);
    run_frame(4, 20, 100);
    run_frame(3, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
